// File: rtl/bcd_encode_scheduler.sv
// ---------------------------------------------------------------------------
// bcd_encode_scheduler
//
// Shares one BCD encoder between NUM_REQ requesters. A round-robin arbiter
// picks one request while idle, the winner's binary value and length are
// driven to the encoder, a one-cycle start pulse is issued, and the encoder's
// packed BCD digits (or an error for a bad length / timeout) are returned on
// a valid/ready response channel. Only one request is in flight at a time.
//
// Handshakes:
//   req channel : req_ready[i] is a combinational, single-cycle accept that is
//                 only ever high in IDLE, for at most one requester; a request
//                 is taken in the cycle where req_valid[i] && req_ready[i].
//   rsp channel : rsp_valid stays high with rsp_id/rsp_bcd/rsp_error stable
//                 until the cycle where rsp_valid && rsp_ready; that cycle is
//                 the transfer and rsp_valid drops on the next cycle.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   req_valid    per-requester request valid            [NUM_REQ]
//   req_ready    per-requester accept (one-hot or zero) [NUM_REQ]
//   req_binary   requester i value at [32i+31:32i]
//   req_length   requester i significant-bit count at [8i+7:8i]
//   enc_binary   value driven to the encoder (held after completion)
//   enc_length   length driven to the encoder (held after completion)
//   enc_start    one-cycle conversion start pulse
//   enc_done     encoder conversion complete
//   enc_bcd      encoder digits {BCD7..BCD0}
//   rsp_valid    response valid
//   rsp_ready    response accept
//   rsp_id       index of the requester served
//   rsp_bcd      packed BCD result {BCD7..BCD0}, 0 on error
//   rsp_error    1 = bad length or encoder timeout
//
// The FSM state is visible as the 'state' signal for checkers.
// ---------------------------------------------------------------------------
module bcd_encode_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_binary,
    input  logic [NUM_REQ*8-1:0]   req_length,
    output logic [31:0]            enc_binary,
    output logic [7:0]             enc_length,
    output logic                   enc_start,
    input  logic                   enc_done,
    input  logic [31:0]            enc_bcd,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [31:0]            rsp_bcd,
    output logic                   rsp_error
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_d;

    logic [IDW-1:0] last;
    logic [TW-1:0]  timer;

    // Per-requester views of the packed request buses.
    logic [31:0]    bin_arr [NUM_REQ];
    logic [7:0]     len_arr [NUM_REQ];

    logic           any_valid;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] cand;
    logic           grant_fire;
    logic [31:0]    win_binary;
    logic [7:0]     win_length;
    logic           len_ok;
    logic           done_ok;
    logic           timeout_hit;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bin_arr[i] = req_binary[i*32 +: 32];
            len_arr[i] = req_length[i*8 +: 8];
        end
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        any_valid = 1'b0;
        gnt       = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last) + k) % NUM_REQ);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                gnt       = cand;
            end
        end
    end

    // rst_n keeps the accept low while reset is held, even with requests up.
    assign grant_fire = (state == IDLE) && any_valid && rst_n;
    assign win_binary = bin_arr[gnt];
    assign win_length = len_arr[gnt];
    assign len_ok     = (win_length != 8'd0) && (win_length <= 8'd32);

    // A done seen on the first WAIT cycle may belong to a previous
    // conversion, so it only counts once the timer has advanced.
    assign done_ok     = enc_done && (timer != '0);
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    always_comb begin
        req_ready = '0;
        if (grant_fire) begin
            req_ready[gnt] = 1'b1;
        end
    end

    assign enc_start = (state == START);
    assign rsp_valid = (state == RESP);

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (grant_fire) begin
                    state_d = len_ok ? START : RESP;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (done_ok || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last       <= IDW'(NUM_REQ - 1);
            timer      <= '0;
            enc_binary <= '0;
            enc_length <= '0;
            rsp_id     <= '0;
            rsp_bcd    <= '0;
            rsp_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        last       <= gnt;
                        rsp_id     <= gnt;
                        enc_binary <= win_binary;
                        enc_length <= win_length;
                        if (!len_ok) begin
                            rsp_bcd   <= '0;
                            rsp_error <= 1'b1;
                        end
                    end
                end
                START: begin
                    timer <= '0;
                end
                WAIT: begin
                    if (done_ok) begin
                        rsp_bcd   <= enc_bcd;
                        rsp_error <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_bcd   <= '0;
                        rsp_error <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_encode_scheduler.md
Name: bcd_encode_scheduler

Overview:
Shares one BCD_Encoder between NUM_REQ requesters. It arbitrates requests round-robin and presents the winner's binary and length to the encoder. It pulses the encoder start, waits for done with a timeout, and returns the packed 8-digit BCD result on a valid/ready response channel. It sits between the display/UART front-ends and the single BCD_Encoder instance.

Parameters:
NUM_REQ, 2, number of requesters (2..4); requester index width IDW = clog2(NUM_REQ), min 1
TIMEOUT, 64, max cycles waited for enc_done before an error response (>=4)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_binary  in  NUM_REQ*32  requester i value at [32i+31:32i]
req_length  in  NUM_REQ*8  requester i significant-bit count at [8i+7:8i]
enc_binary  out  32  value driven to encoder
enc_length  out  8  length driven to encoder
enc_start  out  1  one-cycle conversion start pulse
enc_done  in  1  encoder conversion complete
enc_bcd  in  32  encoder digits {BCD7..BCD0}, 4 bits each
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  index of the requester served
rsp_bcd  out  32  packed BCD result {BCD7..BCD0}
rsp_error  out  1  1 = bad length or timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; timer 0; last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, START, WAIT, RESP.
- IDLE: if any req_valid, grant the first valid index searching upward from last+1 (mod NUM_REQ). req_ready[g]=1 combinationally in that cycle only. Latch binary, length and id; set last=g.
  - Latched length in 1..32: next state START.
  - Length 0 or >32: rsp_bcd=0, rsp_error=1, next state RESP. No enc_start is issued.
- START: enc_start=1 for exactly one cycle. enc_binary/enc_length are driven from the latches and held stable from START until leaving WAIT. timer=0. Next state WAIT.
- WAIT: enc_done is ignored when timer==0, to mask stale done from a previous conversion.
  - enc_done=1 with timer>=1: capture enc_bcd into rsp_bcd, rsp_error=0, go to RESP.
  - Otherwise, if timer==TIMEOUT-1: rsp_bcd=0, rsp_error=1, go to RESP.
  - Otherwise timer++.
- RESP: rsp_valid=1. rsp_id, rsp_bcd and rsp_error stay stable until rsp_ready=1. On the handshake cycle go to IDLE; rsp_valid returns to 0 the next cycle.
- Latency: grant at cycle N, enc_start at N+1, WAIT from N+2. enc_done first seen at cycle M gives rsp_valid at M+1. A bad-length request gives rsp_valid at N+1.
- One request is in flight at a time. req_ready stays 0 outside IDLE.
- A new grant can occur no earlier than the cycle after the rsp handshake.
- Requests that drop req_valid before being granted are simply not served. There is no queueing.
- enc_binary/enc_length keep their last values after completion; enc_start is 0 except in START.
- Reset asserted in any state aborts the operation immediately; no response is produced for the aborted request.

Test Plan:
- Req0 only, binary=162, length=8; encoder model asserts done 10 cycles after start -> one enc_start pulse; rsp_valid with rsp_id=0, rsp_bcd=32'h00000162, rsp_error=0, exactly 1 cycle after done is sampled.
- Req1 only, binary=12345678, length=24 -> rsp_id=1, rsp_bcd=32'h12345678, rsp_error=0.
- Req0 and req1 valid together from reset, three rounds (values 7 and 99) -> grant order 0,1,0,1,0,1. Each req_ready is a single-cycle pulse, never two bits at once.
- Length=0 and, separately, length=40 -> no enc_start pulse; rsp_error=1, rsp_bcd=0, rsp_valid one cycle after grant.
- Encoder never asserts done, TIMEOUT=64 -> rsp_error=1, rsp_bcd=0, rsp_valid at start+65. Also hold enc_done stuck at 1 before start -> it is ignored on the first WAIT cycle and completes on the second.
- Hold rsp_ready=0 for 5 cycles -> rsp fields stable and req_ready=0 throughout. Then pull rst_n low mid-WAIT -> all outputs 0 immediately, and the next request is granted to requester 0 first.
